traffic_phase_scheduler: RTL and testbench

Sequences a four-way intersection through a fixed set of signal phases: NS green, WE green and an optional pedestrian walk phase. It shares that intersection among NS traffic, WE traffic, pedestrian and emergency requesters. Timed yellow and all-red clearance intervals separate every pair of phases. It drives the six lamp outputs of the intersection directly and replaces the free-running light sequence with request-driven arbitration.

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/phase_timer.sv | 29 ++
 rtl/traffic_phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types, default timings and lamp decode for the traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    WE_GREEN  = 3'd3,
    WE_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    SRV_NS  = 2'd0,
    SRV_WE  = 2'd1,
    SRV_PED = 2'd2
  } served_e;

  localparam int GREEN_MIN_DEF = 8;
  localparam int GREEN_MAX_DEF = 20;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 2;
  localparam int WALK_T_DEF    = 6;

  localparam logic EMG_NS = 1'b0;
  localparam logic EMG_WE = 1'b1;

  typedef struct packed {
    logic red_ns;
    logic yellow_ns;
    logic green_ns;
    logic red_we;
    logic yellow_we;
    logic green_we;
    logic walk;
  } lamps_t;

  function automatic lamps_t lamp_decode(input phase_e ph);
    lamps_t l;
    l = '0;
    case (ph)
      NS_GREEN:  begin l.green_ns  = 1'b1; l.red_we = 1'b1; end
      NS_YELLOW: begin l.yellow_ns = 1'b1; l.red_we = 1'b1; end
      WE_GREEN:  begin l.green_we  = 1'b1; l.red_ns = 1'b1; end
      WE_YELLOW: begin l.yellow_we = 1'b1; l.red_ns = 1'b1; end
      PED_WALK:  begin l.red_ns = 1'b1; l.red_we = 1'b1; l.walk = 1'b1; end
      default:   begin l.red_ns = 1'b1; l.red_we = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: sync clear, saturating count, terminal flag once
// the count reaches dur-1 (stays set while saturated).
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (count_reg != '1) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg >= (dur - ONE));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Request-driven four-way intersection phase sequencer with emergency preemption.
// Define TPS_PED_PHASE_EN to include the pedestrian walk phase.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF,
  parameter int WALK_T    = WALK_T_DEF,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       we_req,
  input  logic       ped_req,
  input  logic       emergency,
  input  logic       emg_dir,
  output logic       redNS,
  output logic       yellowNS,
  output logic       greenNS,
  output logic       redWE,
  output logic       yellowWE,
  output logic       greenWE,
  output logic       walk,
  output logic [2:0] phase
);

  phase_e           state_reg, state_next, grant;
  served_e          last_reg, last_next;
  lamps_t           lamps_reg, lamps_next;
  logic             p_ns_reg, p_we_reg, p_ped;
  logic [CNT_W-1:0] dur, count;
  logic             tc, timer_clear;
  logic             min_ok, ns_hold, we_hold, ns_exit, we_exit;

`ifdef TPS_PED_PHASE_EN
  logic p_ped_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_ped_reg <= 1'b0;
    end else begin
      p_ped_reg <= ped_req | (p_ped_reg & ~(timer_clear && state_next == PED_WALK));
    end
  end

  assign p_ped = p_ped_reg;
`else
  logic ped_unused;
  assign ped_unused = ped_req;
  assign p_ped      = 1'b0;
`endif

  always_comb begin
    dur = CNT_W'(ALLRED_T);
    case (state_reg)
      NS_GREEN, WE_GREEN:   dur = CNT_W'(GREEN_MAX);
      NS_YELLOW, WE_YELLOW: dur = CNT_W'(YELLOW_T);
      PED_WALK:             dur = CNT_W'(WALK_T);
      default:              dur = CNT_W'(ALLRED_T);
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .dur   (dur),
    .count (count),
    .tc    (tc)
  );

  // A hold in the matching direction beats every exit rule; an opposing
  // emergency waives the minimum green. tc covers the GREEN_MAX limit.
  assign min_ok  = (count >= CNT_W'(GREEN_MIN - 1));
  assign ns_hold = emergency && (emg_dir == EMG_NS);
  assign we_hold = emergency && (emg_dir == EMG_WE);
  assign ns_exit = !ns_hold && (we_hold || tc || (min_ok && (!ns_req || p_we_reg || p_ped)));
  assign we_exit = !we_hold && (ns_hold || tc || (min_ok && (!we_req || p_ns_reg || p_ped)));

  // Round-robin searches the entries after the last-served one and never
  // re-grants it back to back; with no other candidate the opposite green wins.
  always_comb begin
    grant = (last_reg == SRV_NS) ? WE_GREEN : NS_GREEN;
    if (emergency) begin
      grant = (emg_dir == EMG_WE) ? WE_GREEN : NS_GREEN;
    end else begin
      case (last_reg)
        SRV_NS:  if (p_we_reg) grant = WE_GREEN; else if (p_ped) grant = PED_WALK;
        SRV_WE:  if (p_ped) grant = PED_WALK; else if (p_ns_reg) grant = NS_GREEN;
        default: if (p_ns_reg) grant = NS_GREEN; else if (p_we_reg) grant = WE_GREEN;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ALLRED:    if (tc) state_next = grant;
      NS_GREEN:  if (ns_exit) state_next = NS_YELLOW;
      NS_YELLOW: if (tc) state_next = ALLRED;
      WE_GREEN:  if (we_exit) state_next = WE_YELLOW;
      WE_YELLOW: if (tc) state_next = ALLRED;
`ifdef TPS_PED_PHASE_EN
      PED_WALK:  if (emergency || tc) state_next = ALLRED;
`endif
      default:   state_next = ALLRED;
    endcase
  end

  assign timer_clear = (state_next != state_reg);

  always_comb begin
    last_next = last_reg;
    if (timer_clear) begin
      case (state_next)
        NS_GREEN: last_next = SRV_NS;
        WE_GREEN: last_next = SRV_WE;
        PED_WALK: last_next = SRV_PED;
        default:  last_next = last_reg;
      endcase
    end
  end

  always_comb begin
    lamps_next = lamp_decode(state_next);
`ifndef TPS_PED_PHASE_EN
    lamps_next.walk = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ALLRED;
      last_reg  <= SRV_WE;
      p_ns_reg  <= 1'b0;
      p_we_reg  <= 1'b0;
      lamps_reg <= lamp_decode(ALLRED);
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      p_ns_reg  <= ns_req | (p_ns_reg & ~(timer_clear && state_next == NS_GREEN));
      p_we_reg  <= we_req | (p_we_reg & ~(timer_clear && state_next == WE_GREEN));
      lamps_reg <= lamps_next;
    end
  end

  assign redNS    = lamps_reg.red_ns;
  assign yellowNS = lamps_reg.yellow_ns;
  assign greenNS  = lamps_reg.green_ns;
  assign redWE    = lamps_reg.red_we;
  assign yellowWE = lamps_reg.yellow_we;
  assign greenWE  = lamps_reg.green_we;
  assign walk     = lamps_reg.walk;
  assign phase    = state_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scenario bench: each cycle pushes the expected phase/lamp word to a
// scoreboard and pops it for comparison one time unit after the clock edge.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] P_AR  = 3'd0;
  localparam logic [2:0] P_NSG = 3'd1;
  localparam logic [2:0] P_NSY = 3'd2;
  localparam logic [2:0] P_WEG = 3'd3;
  localparam logic [2:0] P_WEY = 3'd4;
  localparam logic [2:0] P_PED = 3'd5;

  typedef struct {
    string      tag;
    logic [9:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, ns_req, we_req, ped_req, emergency, emg_dir;
  logic       redNS, yellowNS, greenNS, redWE, yellowWE, greenWE, walk;
  logic [2:0] phase;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  traffic_phase_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .ns_req    (ns_req),
    .we_req    (we_req),
    .ped_req   (ped_req),
    .emergency (emergency),
    .emg_dir   (emg_dir),
    .redNS     (redNS),
    .yellowNS  (yellowNS),
    .greenNS   (greenNS),
    .redWE     (redWE),
    .yellowWE  (yellowWE),
    .greenWE   (greenWE),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // {phase, redNS, yellowNS, greenNS, redWE, yellowWE, greenWE, walk}
  function automatic logic [9:0] exp_word(input logic [2:0] ph);
    case (ph)
      P_NSG:   return {ph, 7'b0011000};
      P_NSY:   return {ph, 7'b0101000};
      P_WEG:   return {ph, 7'b1000010};
      P_WEY:   return {ph, 7'b1000100};
      P_PED:   return {ph, 7'b1001001};
      default: return {ph, 7'b1001000};
    endcase
  endfunction

  task automatic step(input string tag, input logic [2:0] ph);
    exp_t       e;
    exp_t       got;
    logic [9:0] obs;
    e.tag  = tag;
    e.word = exp_word(ph);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    obs = {phase, redNS, yellowNS, greenNS, redWE, yellowWE, greenWE, walk};
    n_total++;
    assert (obs === got.word) n_pass++;
    else $error("FAIL %s: observed phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                got.tag, obs[9:7], obs[6:0], got.word[9:7], got.word[6:0]);
  endtask

  task automatic run(input string tag, input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) step(tag, ph);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; ns_req = 1'b0; we_req = 1'b0; ped_req = 1'b0;
    emergency = 1'b0; emg_dir = 1'b0;

    // 1: reset values, then free-running alternation with no demand
    run("reset", P_AR, 3);
    reset = 1'b0;
    run("t1_ar", P_AR, 1);   run("t1_ns", P_NSG, 8);  run("t1_nsy", P_NSY, 3);
    run("t1_ar", P_AR, 2);   run("t1_we", P_WEG, 8);  run("t1_wey", P_WEY, 3);

    // 2: held NS demand runs to the maximum green, then WE is served
    ns_req = 1'b1;
    run("t2_ar", P_AR, 2);   run("t2_ns_max", P_NSG, 20);
    ns_req = 1'b0;
    run("t2_nsy", P_NSY, 3); run("t2_ar", P_AR, 2);   run("t2_we", P_WEG, 8);
    run("t2_wey", P_WEY, 3); run("t2_ar", P_AR, 2);

    // 3: one-cycle WE pulse during NS green
    run("t3_ns", P_NSG, 3);
    we_req = 1'b1; run("t3_ns", P_NSG, 1); we_req = 1'b0;
    run("t3_ns", P_NSG, 4);  run("t3_nsy", P_NSY, 3); run("t3_ar", P_AR, 2);
    check_bit("t3_p_we_set", dut.p_we_reg, 1'b1);
    run("t3_we_entry", P_WEG, 1);
    check_bit("t3_p_we_clr", dut.p_we_reg, 1'b0);

    // 4: pedestrian pulse during WE green
    run("t4_we", P_WEG, 1);
    ped_req = 1'b1; run("t4_we", P_WEG, 1); ped_req = 1'b0;
    run("t4_we", P_WEG, 5);  run("t4_wey", P_WEY, 3); run("t4_ar", P_AR, 2);
`ifdef TPS_PED_PHASE_EN
    run("t4_walk", P_PED, 6); run("t4_ar", P_AR, 2);
`endif

    // 5: WE emergency preempts NS green, WE held past the maximum
    run("t5_ns", P_NSG, 3);
    emergency = 1'b1; emg_dir = 1'b1;
    run("t5_nsy", P_NSY, 3); run("t5_ar", P_AR, 2);  run("t5_we_hold", P_WEG, 30);
    emergency = 1'b0;
    run("t5_wey", P_WEY, 3); run("t5_ar", P_AR, 2);

    // 5b: NS hold, direction flip, emergency dropped during all-red
    run("t5b_ns", P_NSG, 1);
    emergency = 1'b1; emg_dir = 1'b0;
    run("t5b_ns_hold", P_NSG, 24);
    emg_dir = 1'b1;
    run("t5b_nsy", P_NSY, 3); run("t5b_ar", P_AR, 1);
    emergency = 1'b0;
    run("t5b_ar", P_AR, 1);  run("t5b_we", P_WEG, 8); run("t5b_wey", P_WEY, 3);
    run("t5b_ar", P_AR, 2);

    // 6: reset during NS yellow with WE pending
    run("t6_ns", P_NSG, 1);
    we_req = 1'b1; run("t6_ns", P_NSG, 1); we_req = 1'b0;
    run("t6_ns", P_NSG, 6);  run("t6_nsy", P_NSY, 1);
    check_bit("t6_p_we_set", dut.p_we_reg, 1'b1);
    reset = 1'b1;
    run("t6_rst", P_AR, 1);
    check_bit("t6_p_we_rst", dut.p_we_reg, 1'b0);
    run("t6_rst", P_AR, 1);
    reset = 1'b0;
    run("t6_ar", P_AR, 1);   run("t6_ns_first", P_NSG, 8); run("t6_nsy", P_NSY, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
